uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte FIFO and transmit sequencer sitting directly upstream of the UART physical layer's transmit side. Producers write bytes at any rate up to one per clock; the block buffers them and feeds the PHY one byte at a time through its `transmit`/`tx_byte` inputs, pacing on `is_transmitting`. It replaces ad-hoc single-register drivers of the PHY transmit port so bursts (e.g. multi-byte replies) are not lost.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 2..256
- `ADDR_W`, 4, log2(DEPTH); must match DEPTH
- `clk`  in  1  master clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write strobe, one byte per asserted cycle
- `wr_data`  in  8  byte to enqueue
- `full`  out  1  queue holds DEPTH entries
- `empty`  out  1  queue holds 0 entries
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `tx_transmit`  out  1  one-cycle start pulse to PHY `transmit`
- `tx_byte`  out  8  byte to PHY `tx_byte`
- `tx_busy`  in  1  PHY `is_transmitting`
- `clr_ovf`  in  1  clears sticky overflow flag
- `overflow`  out  1  sticky: a write was dropped

## Operation
- Storage: DEPTH x 8 register array, wr_ptr/rd_ptr of ADDR_W bits, wrap modulo DEPTH naturally; `count` is a separate ADDR_W+1 bit register.
- Write: if `wr_en` and not `full` (registered value), store at wr_ptr, wr_ptr+1. Write while `full` is dropped, even if a pop occurs the same cycle.
- Pop: occurs only on the IDLE->ISSUE transition; head byte latched into `tx_byte` register, rd_ptr+1.
- Simultaneous accepted write and pop: `count` unchanged, both pointers advance.
- FSM states:
  - IDLE: if not `empty` and `tx_busy`=0 -> pop, go ISSUE; else stay.
  - ISSUE: `tx_transmit`=1 for this cycle only; go WAIT_BUSY.
  - WAIT_BUSY: wait for `tx_busy`=1 -> WAIT_DONE.
  - WAIT_DONE: wait for `tx_busy`=0 -> IDLE.
- `tx_byte` held stable from ISSUE until next pop; never changes while `tx_busy`=1.
- `full` = (count==DEPTH), `empty` = (count==0), both registered with `count`.
- Reset (any time, including mid-byte): pointers, count, FSM to IDLE, queue contents discarded; PHY finishes any byte in flight independently.

## Timing
- Reset values: `tx_transmit`=0, `tx_byte`=8'h00, `count`=0, `empty`=1, `full`=0, `overflow`=0, FSM IDLE.
- All outputs registered; no combinational path from inputs to outputs.
- Write at edge N into empty queue, FSM IDLE, `tx_busy`=0: `count`=1 after N; pop at N+1 (`count`=0, `tx_byte` valid); `tx_transmit`=1 during cycle after N+1. Write-to-start latency: 2 cycles.
- Back-to-back bytes: next pop at the first edge where FSM is IDLE with `tx_busy`=0, i.e. 1 cycle after `tx_busy` falls; next `tx_transmit` 2 cycles after `tx_busy` falls.
- `tx_busy` high while in IDLE: no pop until it falls.
- `tx_transmit` never asserted two consecutive cycles.

## Configuration
- `UART_TX_QUEUE_OVF_EN` defined: `overflow` sets on the edge of any dropped write, stays set until `clr_ovf`=1; set and clear in same cycle -> set wins.
- Not defined: `overflow` tied to 0, `clr_ovf` ignored; dropped writes still silently discarded.

## Test plan
- Reset release, no writes -> `empty`=1, `count`=0, `tx_transmit` never pulses for 100 cycles.
- Write 8'h77 into idle queue, `tx_busy` model raises 1 cycle after pulse, holds 10 cycles -> `tx_transmit` pulses once 2 cycles after write, `tx_byte`=8'h77 stable throughout busy, `empty`=1 after pop.
- Burst 8'h01..8'h10 (16 writes, DEPTH=16) with `tx_busy` held 1 -> `full`=1, `count`=16; 17th write 8'hAA dropped, `overflow`=1 (macro on) / 0 (macro off); release busy -> bytes emitted in order 01..10, AA never appears.
- Write every cycle while PHY drains: verify simultaneous write+pop keeps `count` constant and pointer wrap after 16+ entries preserves order.
- Assert `rst` low during WAIT_DONE with 5 bytes queued -> `count`=0, `empty`=1, `tx_transmit`=0 immediately; no further pulses after release.
- Macro on: `overflow`=1, assert `clr_ovf` with concurrent dropped write -> `overflow` stays 1; `clr_ovf` alone -> 0 next cycle.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus transmit sequencer feeding a UART PHY one byte at a time.
// Define UART_TX_QUEUE_OVF_EN to enable the sticky overflow flag.
module uart_tx_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              tx_transmit,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  input  logic              clr_ovf,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  state_t            state;
  logic              push;
  logic              pop;

  // A write against a full queue is dropped even if a pop frees a slot that same edge.
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty && !tx_busy;

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == CNT_LAST);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tx_transmit <= 1'b0;
      tx_byte     <= 8'h00;
    end else begin
      tx_transmit <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_byte     <= mem[rd_ptr];
            tx_transmit <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE:     state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_QUEUE_OVF_EN
  // A drop on the same edge as a clear wins so no lost byte goes unreported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized self-checking bench for uart_tx_queue against a queue-based reference model
// and a simple PHY busy model.
module tb_uart_tx_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef UART_TX_QUEUE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              clr_ovf = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              tx_transmit;
  logic [7:0]        tx_byte;
  logic              tx_busy;
  logic              overflow;

  logic phy_busy    = 1'b0;
  logic force_busy  = 1'b0;
  assign tx_busy = phy_busy | force_busy;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .tx_transmit (tx_transmit),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .clr_ovf     (clr_ovf),
    .overflow    (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: queue contents, the byte last handed to the PHY, and the transmit handshake.
  logic [7:0] q[$];
  logic [7:0] m_byte;
  bit m_pulse, m_engaged, m_seen_busy, m_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_byte      = 8'h00;
      m_pulse     = 1'b0;
      m_engaged   = 1'b0;
      m_seen_busy = 1'b0;
      m_ovf       = 1'b0;
    end else begin
      bit was_full;
      was_full = (q.size() == DEPTH);
      if (m_pulse) begin
        m_pulse = 1'b0;
      end else if (m_engaged) begin
        if (!m_seen_busy) begin
          if (tx_busy) m_seen_busy = 1'b1;
        end else if (!tx_busy) begin
          m_engaged = 1'b0;
        end
      end else if (q.size() != 0 && !tx_busy) begin
        m_byte      = q.pop_front();
        m_pulse     = 1'b1;
        m_engaged   = 1'b1;
        m_seen_busy = 1'b0;
      end
      if (wr_en && !was_full) q.push_back(wr_data);
      if (OVF_ON) begin
        if (wr_en && was_full) m_ovf = 1'b1;
        else if (clr_ovf)      m_ovf = 1'b0;
      end
    end
  end

  // PHY model: busy rises one cycle after the start pulse and stays high phy_hold cycles.
  bit         phy_pending = 1'b0;
  int         phy_cnt     = 0;
  int         phy_hold    = 3;
  bit         rand_hold   = 1'b0;
  logic [7:0] emitted[$];
  int         pulses    = 0;
  logic       prev_tx   = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  task automatic phy_update();
    if (phy_pending) begin
      phy_busy    = 1'b1;
      phy_cnt     = rand_hold ? int'($urandom_range(1, 4)) : phy_hold;
      phy_pending = 1'b0;
    end else if (phy_busy) begin
      phy_cnt--;
      if (phy_cnt == 0) phy_busy = 1'b0;
    end
    if (tx_transmit) phy_pending = 1'b1;
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("tx_transmit", 32'(tx_transmit), 32'(m_pulse));
    check("tx_byte", 32'(tx_byte), 32'(m_byte));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tx_no_repeat", 32'(tx_transmit & prev_tx), 32'd0);
    if (tx_busy && prev_busy) check("byte_stable_busy", 32'(tx_byte), 32'(prev_byte));
    if (tx_transmit) begin
      emitted.push_back(tx_byte);
      pulses++;
    end
    prev_tx   = tx_transmit;
    prev_busy = tx_busy;
    prev_byte = tx_byte;
  endtask

  // Inputs change just after a falling edge; outputs are sampled on the next falling edge.
  task automatic step(input bit w, input logic [7:0] d, input bit c);
    wr_en   = w;
    wr_data = d;
    clr_ovf = c;
    @(negedge clk);
    check_outputs();
    phy_update();
  endtask

  task automatic wait_drain(input int budget);
    int i;
    bit drained;
    i = 0;
    while ((q.size() != 0 || m_engaged || phy_busy || phy_pending || tx_busy) && i < budget) begin
      step(1'b0, 8'h00, 1'b0);
      i++;
    end
    drained = (q.size() == 0) && !m_engaged && !tx_busy;
    check("drain_done", 32'(drained), 32'd1);
  endtask

  initial begin
    int n_aa;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_tx_transmit", 32'(tx_transmit), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;

    // Idle after reset: nothing may be issued.
    repeat (100) step(1'b0, 8'h00, 1'b0);
    check("t1_pulses", 32'(pulses), 32'd0);

    // Single byte: the pulse is observed one sample after the write lands (2 cycles from wr_en).
    phy_hold = 10;
    emitted.delete();
    pulses = 0;
    step(1'b1, 8'h77, 1'b0);
    check("t2_count_after_write", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("t2_pulse_latency", 32'(tx_transmit), 32'd1);
    check("t2_empty_after_pop", 32'(empty), 32'd1);
    wait_drain(100);
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_byte", 32'(emitted.size() > 0 ? emitted[0] : 8'hxx), 32'h77);

    // Burst into a blocked PHY, then overflow handling.
    force_busy = 1'b1;
    emitted.delete();
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_count16", 32'(count), 32'd16);
    step(1'b1, 8'hAA, 1'b0);
    check("t3_ovf_set", 32'(overflow), 32'(OVF_ON));
    step(1'b1, 8'hBB, 1'b1);
    check("t6_ovf_set_wins", 32'(overflow), 32'(OVF_ON));
    step(1'b0, 8'h00, 1'b1);
    check("t6_ovf_cleared", 32'(overflow), 32'd0);
    check("t3_count_kept", 32'(count), 32'd16);
    force_busy = 1'b0;
    phy_hold   = 2;
    wait_drain(600);
    check("t3_emitted_n", 32'(emitted.size()), 32'd16);
    n_aa = 0;
    for (int i = 0; i < emitted.size(); i++) begin
      if (i < 16) check("t3_order", 32'(emitted[i]), 32'(i + 1));
      if (emitted[i] == 8'hAA || emitted[i] == 8'hBB) n_aa++;
    end
    check("t3_no_dropped_bytes", 32'(n_aa), 32'd0);

    // Continuous writes while draining: exercises simultaneous push/pop and pointer wrap.
    phy_hold = 1;
    for (int i = 0; i < 80; i++) step(1'b1, 8'($urandom), 1'b0);
    wait_drain(800);

    // Reset while the PHY is mid-byte with five bytes still queued.
    phy_hold = 10;
    pulses   = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("t5_queued", 32'(count), 32'd5);
    check("t5_phy_busy", 32'(phy_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_empty", 32'(empty), 32'd1);
    check("t5_rst_full", 32'(full), 32'd0);
    check("t5_rst_tx_transmit", 32'(tx_transmit), 32'd0);
    @(negedge clk);
    phy_update();
    rst       = 1'b1;
    prev_busy = 1'b0;
    pulses    = 0;
    repeat (40) step(1'b0, 8'h00, 1'b0);
    check("t5_no_pulses", 32'(pulses), 32'd0);

    // Random traffic with random PHY timing and occasional flag clears.
    rand_hold = 1'b1;
    for (int seg = 0; seg < 15; seg++) begin
      int pct;
      pct = int'($urandom_range(5, 95));
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < pct, 8'($urandom), $urandom_range(0, 19) == 0);
    end
    wait_drain(1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
